// File: rtl/led_pattern_core.sv
// led_pattern_core
//
// Drives LED_WIDTH outputs with a static, blinking, rotating or PWM-dimmed
// pattern. The timing is set by a prescaler that wraps every P ACLK cycles.
// The cfg_* inputs are copied into shadow registers only in the LOAD state.
// While in RUN, software changes to cfg_* take effect only after
// cfg_wr_strobe sends the FSM back through LOAD.
//
// Build option: LED_PATTERN_PWM_EN
//    defined   - mode 3 is true PWM (pwm_cnt, duty shadow, comparator)
//    undefined - mode 3 behaves as mode 0 and cfg_duty is ignored
//
// Ports
//    ACLK           in   clock, rising edge
//    ARESETN        in   asynchronous active-low reset
//    cfg_ctrl       in   [0] enable, [2:1] mode (0 static, 1 blink,
//                        2 rotate, 3 PWM)
//    cfg_pattern    in   LED pattern, low LED_WIDTH bits used
//    cfg_period     in   tick period in ACLK cycles, low CNT_WIDTH bits
//                        used (0 is treated as 1)
//    cfg_duty       in   PWM duty, low 8 bits used
//    cfg_wr_strobe  in   one-cycle pulse on any register write; forces a reload
//    led_out        out  registered LED drive
//    tick           out  one-cycle pulse on each prescaler wrap
//    busy           out  high in LOAD or RUN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs low, counters held at 0, wait for enable
// LOAD  | one cycle: copy cfg_* into shadows, clear counters, phase=1
// RUN   | prescaler running; on disable go to IDLE, on strobe go to LOAD

module led_pattern_core #(
    parameter int LED_WIDTH = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [31:0]          cfg_ctrl,
    input  logic [31:0]          cfg_pattern,
    input  logic [31:0]          cfg_period,
    input  logic [31:0]          cfg_duty,
    input  logic                 cfg_wr_strobe,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 tick,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t               state, state_nxt;

    logic [1:0]           mode_sh, mode_nxt;
    logic [LED_WIDTH-1:0] pat_sh, pat_nxt;
    logic [CNT_WIDTH-1:0] per_sh, per_nxt;
    logic [CNT_WIDTH-1:0] presc, presc_nxt;
    logic                 phase, phase_nxt;
    logic [LED_WIDTH-1:0] led_q, led_nxt, led_mode;
`ifdef LED_PATTERN_PWM_EN
    logic [7:0]           duty_sh, duty_nxt;
    logic [7:0]           pwm_cnt, pwm_nxt;
`endif

    logic [CNT_WIDTH-1:0] last;
    logic                 wrap;
    logic                 run_stay;
    logic                 unused_cfg;

    // A zero period behaves like a period of 1, so the terminal count is 0.
    // The subtraction never wraps because the zero case is handled separately.
    assign last     = (per_sh == '0) ? '0 : per_sh - CNT_WIDTH'(1);
    assign wrap     = (presc == last);
    // Disable and reload both take priority over a wrap. In those cycles
    // no tick is produced.
    assign run_stay = (state == RUN) && cfg_ctrl[0] && !cfg_wr_strobe;

    assign tick    = run_stay && wrap;
    assign busy    = (state != IDLE);
    assign led_out = led_q;

    // The upper bits of the config words are don't-care.
    assign unused_cfg = ^{cfg_ctrl, cfg_pattern, cfg_period, cfg_duty};

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_sh;
        pat_nxt   = pat_sh;
        per_nxt   = per_sh;
        presc_nxt = presc;
        phase_nxt = phase;
`ifdef LED_PATTERN_PWM_EN
        duty_nxt  = duty_sh;
        pwm_nxt   = pwm_cnt;
`endif

        case (state)
            IDLE: begin
                presc_nxt = '0;
                phase_nxt = 1'b0;
`ifdef LED_PATTERN_PWM_EN
                pwm_nxt   = '0;
`endif
                if (cfg_ctrl[0]) begin
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                mode_nxt  = cfg_ctrl[2:1];
                pat_nxt   = cfg_pattern[LED_WIDTH-1:0];
                per_nxt   = cfg_period[CNT_WIDTH-1:0];
                presc_nxt = '0;
                phase_nxt = 1'b1;
`ifdef LED_PATTERN_PWM_EN
                duty_nxt  = cfg_duty[7:0];
                pwm_nxt   = '0;
`endif
                state_nxt = RUN;
            end

            RUN: begin
                if (!cfg_ctrl[0]) begin
                    state_nxt = IDLE;
                    presc_nxt = '0;
                    phase_nxt = 1'b0;
`ifdef LED_PATTERN_PWM_EN
                    pwm_nxt   = '0;
`endif
                end else if (cfg_wr_strobe) begin
                    state_nxt = LOAD;
                end else if (wrap) begin
                    presc_nxt = '0;
                    phase_nxt = ~phase;
                    if (mode_sh == 2'd2) begin
                        pat_nxt = (pat_sh << 1) | (pat_sh >> (LED_WIDTH - 1));
                    end
`ifdef LED_PATTERN_PWM_EN
                    pwm_nxt   = pwm_cnt + 8'd1;
`endif
                end else begin
                    presc_nxt = presc + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // led_out is registered. It is computed here from the *next* shadow
        // and counter values, so the first RUN cycle already shows the
        // mode-specific output for prescaler=0.
        led_mode = pat_nxt;
        case (mode_nxt)
            2'd1:    led_mode = phase_nxt ? pat_nxt : '0;
`ifdef LED_PATTERN_PWM_EN
            2'd3:    led_mode = (pwm_nxt < duty_nxt) ? pat_nxt : '0;
`endif
            default: led_mode = pat_nxt;
        endcase

        // During the LOAD cycle the LEDs keep their previous value.
        led_nxt = led_q;
        if (state_nxt == IDLE) begin
            led_nxt = '0;
        end else if (state_nxt == RUN) begin
            led_nxt = led_mode;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            mode_sh <= '0;
            pat_sh  <= '0;
            per_sh  <= '0;
            presc   <= '0;
            phase   <= 1'b0;
            led_q   <= '0;
`ifdef LED_PATTERN_PWM_EN
            duty_sh <= '0;
            pwm_cnt <= '0;
`endif
        end else begin
            mode_sh <= mode_nxt;
            pat_sh  <= pat_nxt;
            per_sh  <= per_nxt;
            presc   <= presc_nxt;
            phase   <= phase_nxt;
            led_q   <= led_nxt;
`ifdef LED_PATTERN_PWM_EN
            duty_sh <= duty_nxt;
            pwm_cnt <= pwm_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_led_pattern_core.sv
// tb_led_pattern_core
//
// The stimulus process sets the inputs one time unit after each rising
// edge. It then pushes the response it expects for that cycle: led_out,
// tick and busy. The monitor samples the DUT on every falling edge and
// compares against the head of the queue whenever an expectation is waiting.

module tb_led_pattern_core;

`ifdef LED_PATTERN_PWM_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] cfg_ctrl;
    logic [31:0] cfg_pattern;
    logic [31:0] cfg_period;
    logic [31:0] cfg_duty;
    logic        cfg_wr_strobe;
    logic [7:0]  led_out;
    logic        tick;
    logic        busy;

    led_pattern_core #(
        .LED_WIDTH(8),
        .CNT_WIDTH(32)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_ctrl     (cfg_ctrl),
        .cfg_pattern  (cfg_pattern),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_wr_strobe(cfg_wr_strobe),
        .led_out      (led_out),
        .tick         (tick),
        .busy         (busy)
    );

    always #5 ACLK = ~ACLK;

    logic [9:0] exp_q[$];
    string      name_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [9:0] exp_cur;
    string      name_cur;

    task automatic next_cyc();
        @(posedge ACLK);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] l,
                              input logic t, input logic b);
        exp_q.push_back({l, t, b});
        name_q.push_back(nm);
    endtask

    initial begin
        forever begin
            @(negedge ACLK);
            if (exp_q.size() > 0) begin
                exp_cur  = exp_q.pop_front();
                name_cur = name_q.pop_front();
                checks++;
                if ({led_out, tick, busy} !== exp_cur) begin
                    failures++;
                    $display("FAIL %s: got led=%h tick=%b busy=%b, expected led=%h tick=%b busy=%b",
                             name_cur, led_out, tick, busy,
                             exp_cur[9:2], exp_cur[1], exp_cur[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [7:0] rot_tab [10];
    logic [7:0] e_led;

    initial begin
        rot_tab = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18,
                    8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};

        ARESETN       = 1'b0;
        cfg_ctrl      = '0;
        cfg_pattern   = '0;
        cfg_period    = '0;
        cfg_duty      = '0;
        cfg_wr_strobe = 1'b0;

        next_cyc(); expect_out("reset", 8'h00, 1'b0, 1'b0);
        next_cyc(); ARESETN = 1'b1; expect_out("release", 8'h00, 1'b0, 1'b0);
        next_cyc(); expect_out("idle hold", 8'h00, 1'b0, 1'b0);

        // Mode 0: static 0x3C, period 3; a pattern change without strobe is ignored.
        next_cyc(); cfg_ctrl = 32'h1; cfg_pattern = 32'h3C; cfg_period = 32'd3;
        expect_out("m0 idle", 8'h00, 1'b0, 1'b0);
        next_cyc(); expect_out("m0 load", 8'h00, 1'b0, 1'b1);
        for (int r = 0; r < 7; r++) begin
            next_cyc();
            if (r == 4) cfg_pattern = 32'hFF;
            expect_out($sformatf("m0 r%0d", r), 8'h3C, (r % 3) == 2, 1'b1);
        end
        next_cyc(); cfg_ctrl = 32'h0; expect_out("m0 disable", 8'h3C, 1'b0, 1'b1);
        next_cyc(); expect_out("m0 to idle", 8'h00, 1'b0, 1'b0);

        // Mode 1: blink 0xA5, period 4, then reload 0x0F on a tick cycle.
        next_cyc(); cfg_ctrl = 32'h3; cfg_pattern = 32'hA5; cfg_period = 32'd4;
        expect_out("m1 idle", 8'h00, 1'b0, 1'b0);
        next_cyc(); expect_out("m1 load", 8'h00, 1'b0, 1'b1);
        for (int r = 0; r < 19; r++) begin
            next_cyc();
            expect_out($sformatf("m1 r%0d", r),
                       (((r / 4) % 2) == 0) ? 8'hA5 : 8'h00, (r % 4) == 3, 1'b1);
        end
        next_cyc(); cfg_pattern = 32'h0F; cfg_wr_strobe = 1'b1;
        expect_out("m1 strobe drops tick", 8'hA5, 1'b0, 1'b1);
        next_cyc(); cfg_wr_strobe = 1'b0;
        expect_out("m1 reload load", 8'hA5, 1'b0, 1'b1);
        for (int s = 0; s < 8; s++) begin
            next_cyc();
            expect_out($sformatf("m1 reload s%0d", s),
                       (s < 4) ? 8'h0F : 8'h00, (s % 4) == 3, 1'b1);
        end
        next_cyc(); cfg_ctrl = 32'h0; expect_out("m1 disable", 8'h0F, 1'b0, 1'b1);
        next_cyc(); expect_out("m1 to idle", 8'h00, 1'b0, 1'b0);

        // Mode 2: rotate 0x81, period 1.
        next_cyc(); cfg_ctrl = 32'h5; cfg_pattern = 32'h81; cfg_period = 32'd1;
        expect_out("m2 idle", 8'h00, 1'b0, 1'b0);
        next_cyc(); expect_out("m2 load", 8'h00, 1'b0, 1'b1);
        for (int r = 0; r < 10; r++) begin
            next_cyc();
            expect_out($sformatf("m2 r%0d", r), rot_tab[r], 1'b1, 1'b1);
        end
        next_cyc(); cfg_ctrl = 32'h0;
        next_cyc(); expect_out("m2 to idle", 8'h00, 1'b0, 1'b0);

        // Mode 3: 0xFF, duty 64, period 1; then reload with duty 0.
        next_cyc(); cfg_ctrl = 32'h7; cfg_pattern = 32'hFF; cfg_period = 32'd1;
        cfg_duty = 32'd64;
        expect_out("m3 idle", 8'h00, 1'b0, 1'b0);
        next_cyc(); expect_out("m3 load", 8'h00, 1'b0, 1'b1);
        for (int r = 0; r < 300; r++) begin
            next_cyc();
            e_led = (PWM_ON && ((r % 256) >= 64)) ? 8'h00 : 8'hFF;
            expect_out($sformatf("m3 r%0d", r), e_led, 1'b1, 1'b1);
        end
        // pwm_cnt is 300 mod 256 = 44 here, which is below 64, so the LEDs are on.
        next_cyc(); cfg_duty = 32'd0; cfg_wr_strobe = 1'b1;
        expect_out("m3 strobe drops tick", 8'hFF, 1'b0, 1'b1);
        next_cyc(); cfg_wr_strobe = 1'b0;
        expect_out("m3 reload load", 8'hFF, 1'b0, 1'b1);
        for (int r = 0; r < 20; r++) begin
            next_cyc();
            expect_out($sformatf("m3 duty0 r%0d", r), PWM_ON ? 8'h00 : 8'hFF, 1'b1, 1'b1);
        end
        next_cyc(); cfg_ctrl = 32'h0;
        next_cyc(); expect_out("m3 to idle", 8'h00, 1'b0, 1'b0);

        // Reset mid-RUN while led_out is 0xA5, then run with period 0.
        next_cyc(); cfg_ctrl = 32'h3; cfg_pattern = 32'hA5; cfg_period = 32'd4;
        expect_out("rst idle", 8'h00, 1'b0, 1'b0);
        next_cyc(); expect_out("rst load", 8'h00, 1'b0, 1'b1);
        next_cyc(); expect_out("rst r0", 8'hA5, 1'b0, 1'b1);
        next_cyc(); expect_out("rst r1", 8'hA5, 1'b0, 1'b1);
        next_cyc();
        checks++;
        if (led_out !== 8'hA5) begin
            failures++;
            $display("FAIL pre-reset led: got %h expected a5", led_out);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL pre-reset busy: got %b expected 1", busy);
        end
        ARESETN = 1'b0; cfg_period = 32'd0;
        #1;
        checks++;
        if (led_out !== 8'h00) begin
            failures++;
            $display("FAIL async reset led: got %h expected 00", led_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL async reset busy: got %b expected 0", busy);
        end
        checks++;
        if (tick !== 1'b0) begin
            failures++;
            $display("FAIL async reset tick: got %b expected 0", tick);
        end
        expect_out("async reset", 8'h00, 1'b0, 1'b0);
        next_cyc(); expect_out("reset held", 8'h00, 1'b0, 1'b0);
        next_cyc(); ARESETN = 1'b1;
        expect_out("release idle", 8'h00, 1'b0, 1'b0);
        next_cyc(); expect_out("p0 load", 8'h00, 1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            next_cyc();
            expect_out($sformatf("p0 r%0d", r),
                       ((r % 2) == 0) ? 8'hA5 : 8'h00, 1'b1, 1'b1);
        end
        next_cyc(); cfg_ctrl = 32'h0;
        next_cyc();
        @(negedge ACLK);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_core.md
LED_PATTERN_CORE -- requirements
Module: led_pattern_core

Interface
REQ-001 Parameter: LED_WIDTH, 8, number of external LED outputs (1..32).
REQ-002 Parameter: CNT_WIDTH, 32, prescaler counter width.
REQ-003 Port: ACLK  in  1  single clock; all logic on rising edge.
REQ-004 Port: ARESETN  in  1  asynchronous active-low reset.
REQ-005 Port: cfg_ctrl  in  32  bit0 enable, bits[2:1] mode (0 static, 1 blink, 2 rotate, 3 PWM); other bits ignored.
REQ-006 Port: cfg_pattern  in  32  LED pattern; bits[LED_WIDTH-1:0] used.
REQ-007 Port: cfg_period  in  32  tick period in ACLK cycles; bits[CNT_WIDTH-1:0] used.
REQ-008 Port: cfg_duty  in  32  PWM duty; bits[7:0] used.
REQ-009 Port: cfg_wr_strobe  in  1  one-cycle pulse when the upstream AXI4-Lite register file commits any write.
REQ-010 Port: led_out  out  LED_WIDTH  registered LED drive.
REQ-011 Port: tick  out  1  one-cycle pulse at each prescaler wrap.
REQ-012 Port: busy  out  1  high while the FSM is in LOAD or RUN.

Function
REQ-013 The FSM shall have states IDLE, LOAD and RUN.
REQ-014 IDLE: led_out=0, tick=0, counters held at 0; cfg_ctrl[0]=1 -> LOAD.
REQ-015 LOAD (exactly one cycle): shadow mode, pattern, period and duty from cfg_*; prescaler=0, pwm_cnt=0, blink phase=1 -> RUN.
REQ-016 RUN: cfg_ctrl[0]=0 -> IDLE (highest priority); else cfg_wr_strobe=1 -> LOAD; else stay in RUN.
REQ-017 cfg_* shall be sampled only in LOAD; changes without cfg_wr_strobe shall have no effect in RUN.
REQ-018 Effective period P = shadow period, with P=0 treated as 1.
REQ-019 In RUN the prescaler shall count 0..P-1; on the cycle it equals P-1 it shall return to 0 and tick shall be 1 for exactly that cycle.
REQ-020 Mode 0: led_out = shadow pattern; tick is still generated.
REQ-021 Mode 1: phase toggles on each tick; led_out = phase ? pattern : 0.
REQ-022 Mode 2: on each tick, pattern rotates left by one (MSB wraps to bit 0); led_out = current pattern.
REQ-023 Mode 3: 8-bit pwm_cnt increments on each tick and wraps 255->0; led_out = (pwm_cnt < duty) ? pattern : 0.
REQ-024 led_out shall be registered; the first RUN cycle after LOAD shall already show the mode-specific output for prescaler=0.
REQ-025 A tick coinciding with cfg_wr_strobe shall be dropped; the reload wins.
REQ-026 A transition to IDLE shall force led_out=0 on the following edge.
REQ-027 The prescaler shall wrap exactly at P-1 with no overflow for P = 2^CNT_WIDTH-1.

Reset
REQ-028 ARESETN low shall immediately force state=IDLE, led_out=0, tick=0, busy=0, and all counters and shadows to 0, regardless of clock.
REQ-029 Reset release shall take effect synchronously; the first LOAD shall occur no earlier than the first edge after release with enable=1.
REQ-030 Reset asserted mid-RUN shall abort with no partial tick pulse.

Configuration
REQ-031 Macro LED_PATTERN_PWM_EN shall compile in mode 3 PWM logic (pwm_cnt, duty shadow, comparator).
REQ-032 Without LED_PATTERN_PWM_EN, mode 3 shall behave as mode 0 and cfg_duty shall be ignored; no pwm_cnt logic shall exist.

Verification
REQ-033 Scenario: mode 0, pattern 0x3C, enable -> busy=1 after 1 cycle; led_out=0x3C steady; tick every P cycles.
REQ-034 Scenario: mode 1, pattern 0xA5, period 4 -> led_out alternates 0xA5 and 0x00 in 4-cycle runs; tick every 4 cycles.
REQ-035 Scenario: mode 2, pattern 0x81, period 1 -> led_out sequence 0x81, 0x03, 0x06, 0x0C, ..., back to 0x81 after 8 ticks.
REQ-036 Scenario: mode 3 (macro defined), pattern 0xFF, duty 64, period 1 -> led_out=0xFF for 64 of every 256 cycles; duty 0 -> always 0x00.
REQ-037 Scenario: in RUN, mode 1, pattern 0xA5; write pattern 0x0F with cfg_wr_strobe on a tick cycle -> no tick that cycle, one LOAD cycle, then 0x0F with phase=1.
REQ-038 Scenario: ARESETN pulled low mid-RUN with led_out=0xA5 -> led_out=0x00 and busy=0 asynchronously; period 0 afterwards -> tick on every RUN cycle.
